// File: rtl/fp_add_feeder.sv
// Sequencer for the single-port FP32 adder: serialises operand pairs into the adder's
// ready windows and returns only the results of operations it committed.
module fp_add_feeder #(
  parameter int TIMEOUT_CYCLES = 512,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [31:0]      add_a,
  input  logic             add_ready,
  input  logic [31:0]      add_sum,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DRV_A     = 2'd1;
  localparam logic [1:0] DRV_B     = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic             pend_valid;
  logic             in_flight;
  logic             rdy_q;
  logic [31:0]      pend_a;
  logic [31:0]      pend_b;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [TMO_W-1:0] tmo_cnt;
  logic             rise;
  logic             slot_free;
  logic             commit;
  logic             done;
  logic             expire;

  // A window starts on the first cycle of add_ready; rdy_q resets high so a window
  // already open at reset release is never mistaken for a fresh one.
  assign rise      = add_ready & ~rdy_q;
  assign slot_free = ~out_valid | out_ready;
  assign commit    = (state == IDLE) & rise & pend_valid & slot_free & ~in_flight;
  assign done      = (state == WAIT_DONE) & rise;
  assign expire    = (state == WAIT_DONE) & ~rise & (tmo_cnt == TMO_LAST);
  assign in_ready  = ~pend_valid;
  assign busy      = pend_valid | (state != IDLE);

  // Operand A is driven combinationally in the commit cycle so it covers both ready cycles.
  always_comb begin
    add_a = '0;
    case (state)
      IDLE:    if (commit) add_a = pend_a;
      DRV_A:   add_a = op_a;
      DRV_B:   add_a = op_b;
      default: add_a = '0;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) rdy_q <= 1'b1;
    else         rdy_q <= add_ready;
  end

  // Holding register frees up as soon as its pair is committed.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pend_valid <= 1'b0;
      pend_a     <= '0;
      pend_b     <= '0;
    end else if (commit) begin
      pend_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      pend_valid <= 1'b1;
      pend_a     <= in_a;
      pend_b     <= in_b;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      in_flight <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (commit) begin
            state <= DRV_A;
            op_a  <= pend_a;
            op_b  <= pend_b;
          end
        end
        DRV_A: state <= DRV_B;
        DRV_B: begin
          state     <= WAIT_DONE;
          in_flight <= 1'b1;
          tmo_cnt   <= '0;
        end
        WAIT_DONE: begin
          if (done || expire) begin
            state     <= IDLE;
            in_flight <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Results of uncommitted operations never reach here because done needs WAIT_DONE.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid   <= 1'b0;
      out_sum     <= '0;
      op_count    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (done) begin
        out_valid <= 1'b1;
        out_sum   <= add_sum;
        op_count  <= op_count + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (expire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add_feeder.sv
// Testbench for fp_add_feeder: free-running adder stub plus an in-order result scoreboard.
module tb_fp_add_feeder;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 16;
  localparam int PERIOD         = 6;

  logic             clock = 1'b0;
  logic             nreset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [31:0]      add_a;
  logic             add_ready;
  logic [31:0]      add_sum;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] op_count;

  int          tests = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          phase = 0;
  int          cur_phase = 0;
  logic        adder_stall = 1'b0;
  logic [31:0] samp_a = '0;
  logic [31:0] samp_b = '0;

  always #5 clock = ~clock;

  fp_add_feeder #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) dut (
    .clock(clock), .nreset(nreset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .add_a(add_a), .add_ready(add_ready), .add_sum(add_sum),
    .busy(busy), .timeout_err(timeout_err), .op_count(op_count)
  );

  // Known FP32 sums; anything else (including 0+0 garbage ops) yields a distinctive nonzero word.
  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3FC00000, 32'hBF000000}: return 32'h3F800000;
      {32'h40000000, 32'h40400000}: return 32'h40A00000;
      {32'h40400000, 32'h40400000}: return 32'h40C00000;
      {32'h40800000, 32'h3F800000}: return 32'h40A00000;
      {32'h41000000, 32'h41000000}: return 32'h41800000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      default:                      return {a[15:0], b[31:16]} ^ 32'hA5A50F0F;
    endcase
  endfunction

  initial begin : adder_stub
    logic st;
    add_ready = 1'b0;
    add_sum   = 32'h0;
    forever begin
      @(posedge clock); #1;
      st        = adder_stall;
      cur_phase = phase;
      add_ready = !st && (phase < 2);
      @(negedge clock);
      if (!st && cur_phase == 1) samp_a = add_a;
      if (!st && cur_phase == 2) begin
        samp_b  = add_a;
        add_sum = adder_model(samp_a, samp_b);
      end
      phase = st ? 0 : (phase + 1) % PERIOD;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] sum, input bit expect_result);
    int n = 0;
    @(posedge clock); #2;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 100);
    checkOutput("in_accept", 32'(in_ready), 32'd1);
    @(posedge clock); #2;
    in_valid = 1'b0;
    if (expect_result) exp_q.push_back(sum);
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic waitDrvB(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(add_a != 32'h0 && !add_ready) && n < 50);
    checkOutput(tag, 32'(add_ready), 32'd0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (nreset && out_valid && out_ready) begin
        if (exp_q.size() == 0) checkOutput("out_spurious", 32'(out_valid), 32'd0);
        else                   checkOutput("out_sum", out_sum, exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int   n;
    logic seen;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    nreset    = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum", out_sum, 32'h0);
    checkOutput("rst_add_a", add_a, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    checkOutput("rst_op_count", 32'(op_count), 32'd0);
    @(posedge clock); #2;
    nreset = 1'b1;

    // Operand serialisation: A across both ready cycles, then B once.
    applyStimulus(32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (add_a == 32'h0 && n < 50);
    checkOutput("t1_a_first", add_a, 32'h3F800000);
    checkOutput("t1_rdy_first", 32'(add_ready), 32'd1);
    @(negedge clock);
    checkOutput("t1_a_second", add_a, 32'h3F800000);
    checkOutput("t1_rdy_second", 32'(add_ready), 32'd1);
    @(negedge clock);
    checkOutput("t1_b", add_a, 32'h40000000);
    checkOutput("t1_rdy_low", 32'(add_ready), 32'd0);
    @(negedge clock);
    checkOutput("t1_after", add_a, 32'h0);
    waitDrain("t1_drain");
    checkOutput("t1_op_count", 32'(op_count), 32'd1);

    applyStimulus(32'h3FC00000, 32'hBF000000, 32'h3F800000, 1'b1);
    waitDrain("t2_drain");
    checkOutput("t2_op_count", 32'(op_count), 32'd2);

    // Free-running adder with nothing committed must produce no output.
    seen = 1'b0;
    repeat (5 * PERIOD) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("idle_no_out", 32'(seen), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Backpressure: held result blocks the next commit.
    @(posedge clock); #2;
    out_ready = 1'b0;
    applyStimulus(32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
    applyStimulus(32'h40000000, 32'h40400000, 32'h40A00000, 1'b1);
    seen = 1'b0;
    repeat (3 * PERIOD) begin
      @(negedge clock);
      if (add_a != 32'h0) seen = 1'b1;
    end
    checkOutput("bp_no_commit", 32'(seen), 32'd0);
    checkOutput("bp_hold_sum", out_sum, 32'h40400000);
    checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_busy", 32'(busy), 32'd1);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_op_count", 32'(op_count), 32'd3);
    @(posedge clock); #2;
    out_ready = 1'b1;
    waitDrain("bp_drain");
    checkOutput("bp_op_count_end", 32'(op_count), 32'd4);

    // Pair arriving in the 2nd ready cycle waits for the next window.
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(add_ready && cur_phase == 0) && n < 50);
    @(posedge clock); #2;
    in_a     = 32'h40400000;
    in_b     = 32'h40400000;
    in_valid = 1'b1;
    @(negedge clock);
    checkOutput("late_no_drive", add_a, 32'h0);
    checkOutput("late_accept", 32'(in_ready), 32'd1);
    @(posedge clock); #2;
    in_valid = 1'b0;
    exp_q.push_back(32'h40C00000);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (add_a == 32'h0 && n < 50);
    checkOutput("late_commit_a", add_a, 32'h40400000);
    checkOutput("late_commit_phase", 32'(cur_phase), 32'd0);
    waitDrain("late_drain");
    checkOutput("late_op_count", 32'(op_count), 32'd5);

    // Adder goes silent after commit: op abandoned after TIMEOUT_CYCLES.
    applyStimulus(32'h3F800000, 32'h3F800000, 32'h0, 1'b0);
    waitDrvB("tmo_drv_b");
    adder_stall = 1'b1;
    repeat (TIMEOUT_CYCLES) @(negedge clock);
    checkOutput("tmo_not_yet", 32'(timeout_err), 32'd0);
    checkOutput("tmo_busy_wait", 32'(busy), 32'd1);
    @(negedge clock);
    checkOutput("tmo_err", 32'(timeout_err), 32'd1);
    checkOutput("tmo_busy", 32'(busy), 32'd0);
    checkOutput("tmo_out_valid", 32'(out_valid), 32'd0);
    @(posedge clock); #2;
    adder_stall = 1'b0;
    applyStimulus(32'h40800000, 32'h3F800000, 32'h40A00000, 1'b1);
    waitDrain("tmo_next_drain");
    checkOutput("tmo_op_count", 32'(op_count), 32'd6);
    checkOutput("tmo_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT_DONE, released while add_ready is high.
    applyStimulus(32'h41000000, 32'h41000000, 32'h0, 1'b0);
    waitDrvB("mid_drv_b");
    @(posedge clock); #2;
    nreset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_out_sum", out_sum, 32'h0);
    checkOutput("mid_add_a", add_a, 32'h0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_timeout", 32'(timeout_err), 32'd0);
    checkOutput("mid_op_count", 32'(op_count), 32'd0);
    checkOutput("mid_in_ready", 32'(in_ready), 32'd1);
    n = 0;
    do begin
      @(posedge clock); #2;
      n++;
    end while (!add_ready && n < 20);
    checkOutput("mid_rel_rdy", 32'(add_ready), 32'd1);
    nreset = 1'b1;
    seen = 1'b0;
    repeat (2 * PERIOD) begin
      @(negedge clock);
      if (out_valid || busy) seen = 1'b1;
    end
    checkOutput("mid_quiet", 32'(seen), 32'd0);
    applyStimulus(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
    waitDrain("mid_next_drain");
    checkOutput("mid_op_count_end", 32'(op_count), 32'd1);

    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
